// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon 64/128 CBC front end.
// Holds the state encoding, the block/key types and the default N, M and TIMEOUT.
package simon_pkg;

    localparam int DEF_N       = 32;
    localparam int DEF_M       = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef logic [2*DEF_N-1:0]     block_t;
    typedef logic [DEF_N*DEF_M-1:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_CRST,
        ST_CEN,
        ST_WAIT,
        ST_OUT
    } cbc_state_t;

endpackage

// File: rtl/simon_cbc_ctrl_if.sv
// Host-side bundle: message start, plaintext stream in, ciphertext stream out, status.
// master = host data path, slave = the CBC controller.
interface simon_cbc_ctrl_if
    import simon_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
);
    logic             start;
    logic [N*M-1:0]   key;
    logic [2*N-1:0]   iv;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_data;
    logic             out_last;
    logic             busy;
    logic             timeout_err;

    modport master (
        output start, key, iv, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, timeout_err
    );

    modport slave (
        input  start, key, iv, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, timeout_err
    );
endinterface

// File: rtl/simon_cbc_watchdog.sv
// Loadable down-counter bounding the wait for core_done; expired fires in the
// TIMEOUT-th cycle of run after a load. Holds its value while run is low.
module simon_cbc_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(TIMEOUT);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // Counting down from TIMEOUT, the last permitted cycle is the one holding 1.
    assign expired = run && (cnt == W'(1));

endmodule

// File: rtl/simon_cbc_ctrl.sv
// CBC chaining front end for the Simon core: one block in flight, out_valid L+3 cycles
// after input accept; out_ready low parks the block in OUT indefinitely (watchdog paused).
module simon_cbc_ctrl
    import simon_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int M       = DEF_M,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    simon_cbc_ctrl_if.slave      host,
    output logic                 core_rst,
    output logic                 core_en,
    output logic [N*M-1:0]       core_key,
    output logic [2*N-1:0]       core_plaintext,
    input  logic [2*N-1:0]       core_ciphertext,
    input  logic                 core_done
);

    cbc_state_t     state;
    cbc_state_t     state_nxt;
    logic [N*M-1:0] key_r;
    logic [2*N-1:0] chain_r;
    logic [2*N-1:0] blk_r;
    logic [2*N-1:0] out_r;
    logic           last_r;
    logic           err_r;
    logic           wd_load;
    logic           wd_run;
    logic           wd_expired;

    simon_cbc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load),
        .run     (wd_run),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        wd_load   = 1'b0;
        wd_run    = 1'b0;
        unique case (state)
            ST_IDLE:  if (host.start)    state_nxt = ST_READY;
            ST_READY: if (host.in_valid) state_nxt = ST_CRST;
            ST_CRST:  state_nxt = ST_CEN;
            ST_CEN: begin
                wd_load   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                wd_run = 1'b1;
                // A result arriving in the expiry cycle still wins.
                if (core_done)       state_nxt = ST_OUT;
                else if (wd_expired) state_nxt = ST_IDLE;
            end
            ST_OUT:   if (host.out_ready) state_nxt = last_r ? ST_IDLE : ST_READY;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            key_r   <= '0;
            chain_r <= '0;
            blk_r   <= '0;
            out_r   <= '0;
            last_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (host.start) begin
                        key_r   <= host.key;
                        chain_r <= host.iv;
                        err_r   <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (host.in_valid) begin
                        blk_r  <= host.in_data ^ chain_r;
                        last_r <= host.in_last;
                    end
                end
                ST_WAIT: begin
                    if (core_done)       out_r <= core_ciphertext;
                    else if (wd_expired) err_r <= 1'b1;
                end
                ST_OUT: begin
                    if (host.out_ready) chain_r <= out_r;
                end
                default: ;
            endcase
        end
    end

    assign host.in_ready    = (state == ST_READY);
    assign host.out_valid   = (state == ST_OUT);
    assign host.out_data    = out_r;
    assign host.out_last    = last_r;
    assign host.busy        = (state != ST_IDLE);
    assign host.timeout_err = err_r;

    assign core_rst       = rst | (state == ST_CRST);
    assign core_en        = (state == ST_CEN);
    assign core_key       = key_r;
    assign core_plaintext = blk_r;

endmodule

// File: tb/tb_simon_cbc_ctrl.sv
// Directed bench for simon_cbc_ctrl with a table-driven Simon core stand-in and an
// output scoreboard fed by the stimulus and drained by an independent monitor.
module tb_simon_cbc_ctrl;
    import simon_pkg::*;

    localparam key_t   KEY  = 128'h1b1a1918131211100b0a090803020100;
    localparam block_t PT1  = 64'h656b696c20646e75;
    localparam block_t CT1  = 64'h44c8fc20b9dfa07a;
    localparam block_t PT2  = 64'h21a3954c99bbce0f;
    localparam block_t IV2  = 64'h0123456789abcdef;
    localparam block_t PTIV = 64'h64482c0ba9cfa39a;

    typedef struct packed {
        block_t dat;
        logic   last;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   core_rst;
    logic   core_en;
    key_t   core_key;
    block_t core_plaintext;
    block_t core_ciphertext;
    logic   core_done;

    simon_cbc_ctrl_if host ();

    simon_cbc_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .host            (host),
        .core_rst        (core_rst),
        .core_en         (core_en),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_ciphertext (core_ciphertext),
        .core_done       (core_done)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_xfer = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Core stand-in: only the published test vector encrypts to CT1.
    function automatic block_t core_model(input key_t k, input block_t p);
        block_t lo;
        lo = k[63:0];
        if (k == KEY && p == PT1) return CT1;
        return p ^ lo ^ 64'h0f1e2d3c4b5a6978;
    endfunction

    int core_lat  = 4;
    bit core_hang = 1'b0;
    int core_cnt  = 0;

    always @(posedge clk) begin
        if (core_rst) begin
            core_cnt  <= 0;
            core_done <= 1'b0;
        end else if (core_en) begin
            core_cnt <= core_lat;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !core_hang) begin
                core_done       <= 1'b1;
                core_ciphertext <= core_model(core_key, core_plaintext);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && host.out_valid && host.out_ready) begin
            n_xfer++;
            check("out_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("out_data", 128'(host.out_data), 128'(mon_e.dat));
                check("out_last", 128'(host.out_last), 128'(mon_e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_msg(input key_t k, input block_t v);
        host.start = 1'b1;
        host.key   = k;
        host.iv    = v;
        tick();
        host.start = 1'b0;
    endtask

    task automatic send(input block_t d, input logic l);
        int t;
        t = 0;
        host.in_valid = 1'b1;
        host.in_data  = d;
        host.in_last  = l;
        @(negedge clk);
        while (!host.in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", 128'(host.in_ready), 128'(1));
        tick();
        host.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!host.out_valid && cycles < 1000) begin
            tick();
            cycles++;
        end
        check("out_valid_wait", 128'(host.out_valid), 128'(1));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (host.busy && t < 1000) begin
            tick();
            t++;
        end
        check("idle_wait", 128'(host.busy), 128'(0));
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready",    128'(host.in_ready),    128'(0));
        check("rst_out_valid",   128'(host.out_valid),   128'(0));
        check("rst_out_last",    128'(host.out_last),    128'(0));
        check("rst_busy",        128'(host.busy),        128'(0));
        check("rst_timeout_err", 128'(host.timeout_err), 128'(0));
        check("rst_core_en",     128'(core_en),          128'(0));
        check("rst_core_rst",    128'(core_rst),         128'(1));
        check("rst_out_data",    128'(host.out_data),    128'(0));
        check("rst_core_pt",     128'(core_plaintext),   128'(0));
        check("rst_core_key",    128'(core_key),         128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int lat;
        int nwait;
        int base;

        rst           = 1'b1;
        host.start    = 1'b0;
        host.key      = '0;
        host.iv       = '0;
        host.in_valid = 1'b0;
        host.in_data  = '0;
        host.in_last  = 1'b0;
        host.out_ready = 1'b1;
        core_ciphertext = '0;
        tick();
        tick();
        check_reset_vals();
        rst = 1'b0;
        tick();

        // Single block, IV=0, with latency and return to IDLE.
        core_lat = 4;
        open_msg(KEY, '0);
        exp_q.push_back('{CT1, 1'b1});
        send(PT1, 1'b1);
        wait_out(lat);
        check("latency", 128'(lat), 128'(core_lat + 3));
        tick();
        check("idle_after_last", 128'(host.busy), 128'(0));

        // Two-block chain: block 2 reaches the core as PT1.
        core_lat = 6;
        open_msg(KEY, '0);
        exp_q.push_back('{CT1, 1'b0});
        send(PT1, 1'b0);
        wait_out(lat);
        tick();
        check("ready_after_out", 128'(host.in_ready), 128'(1));
        exp_q.push_back('{CT1, 1'b1});
        send(PT2, 1'b1);
        check("blk2_core_pt", 128'(core_plaintext), 128'(PT1));
        wait_idle();

        // Non-zero IV folds into the first block.
        open_msg(KEY, IV2);
        exp_q.push_back('{CT1, 1'b1});
        send(PTIV, 1'b1);
        check("iv_core_pt", 128'(core_plaintext), 128'(PT1));
        wait_idle();

        // Back-pressure: 20 stalled cycles, then exactly one transfer.
        host.out_ready = 1'b0;
        open_msg(KEY, '0);
        exp_q.push_back('{CT1, 1'b1});
        send(PT1, 1'b1);
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", 128'(host.out_valid), 128'(1));
            check("bp_out_data",  128'(host.out_data),  128'(CT1));
            check("bp_in_ready",  128'(host.in_ready),  128'(0));
            tick();
        end
        base = n_xfer;
        host.out_ready = 1'b1;
        tick();
        tick();
        check("bp_one_xfer", 128'(n_xfer - base), 128'(1));
        check("bp_released", 128'(host.out_valid), 128'(0));

        // Timeout: core never finishes.
        core_hang = 1'b1;
        open_msg(KEY, '0);
        send(PT1, 1'b1);
        nwait = 0;
        for (int i = 0; i < 600 && host.busy; i++) begin
            tick();
            if (host.busy && !core_rst && !core_en && !host.in_ready && !host.out_valid) nwait++;
        end
        check("to_wait_cycles", 128'(nwait), 128'(255));
        check("to_err_set",     128'(host.timeout_err), 128'(1));
        check("to_idle",        128'(host.busy), 128'(0));
        open_msg(KEY, '0);
        check("to_err_cleared", 128'(host.timeout_err), 128'(0));
        check("to_reopened",    128'(host.in_ready), 128'(1));

        // Reset mid-WAIT drops the in-flight block.
        send(PT1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("mid_wait_busy", 128'(host.busy), 128'(1));
        rst = 1'b1;
        #1;
        check("core_rst_with_rst", 128'(core_rst), 128'(1));
        tick();
        check_reset_vals();
        rst = 1'b0;
        #1;
        check("core_rst_released", 128'(core_rst), 128'(0));
        core_hang = 1'b0;
        tick();
        open_msg(KEY, '0);
        exp_q.push_back('{CT1, 1'b1});
        send(PT1, 1'b1);
        wait_idle();

        // Ignored start during WAIT and in_valid held while busy.
        open_msg(KEY, '0);
        exp_q.push_back('{CT1, 1'b0});
        send(PT1, 1'b0);
        host.in_valid = 1'b1;
        host.in_data  = 64'hffff0000ffff0000;
        host.in_last  = 1'b1;
        tick();
        tick();
        host.start = 1'b1;
        host.key   = ~KEY;
        host.iv    = 64'h1234;
        tick();
        host.start = 1'b0;
        check("ign_core_key", 128'(core_key), 128'(KEY));
        check("ign_core_pt",  128'(core_plaintext), 128'(PT1));
        wait_out(lat);
        exp_q.push_back('{CT1, 1'b1});
        send(PT2, 1'b1);
        check("ign_blk2_core_pt", 128'(core_plaintext), 128'(PT1));
        wait_idle();
        tick();

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_cbc_ctrl.md
# simon_cbc_ctrl

Streaming CBC-mode front end for the Simon 64/128 core (`simon`, n=32, m=4). It accepts plaintext blocks over a valid/ready stream and XORs each with the chaining value (the IV, then the previous ciphertext). It drives the core's `rst`/`en`/`done` handshake per block and returns ciphertext over a second valid/ready stream. It sits between the host data path and the core and owns all chaining state.

## Interface
- `N`, 32, Simon word size; block = 2*N bits.
- `M`, 4, key words; key = N*M bits.
- `TIMEOUT`, 255, max cycles to wait for `core_done` before aborting.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle pulse; latches `key`/`iv`, opens a message. Ignored unless in IDLE.
- `key` in N*M — cipher key, sampled on accepted `start`.
- `iv` in 2N — initial chaining value, sampled on accepted `start`.
- `in_valid`, `in_ready` in/out 1 — plaintext stream handshake.
- `in_data` in 2N — plaintext block.
- `in_last` in 1 — final block of message.
- `out_valid`, `out_ready` out/in 1 — ciphertext stream handshake.
- `out_data` out 2N — ciphertext block.
- `out_last` out 1 — copy of accepted `in_last`.
- `busy` out 1 — high in any state except IDLE.
- `timeout_err` out 1 — sticky; set on core timeout, cleared by `rst` or accepted `start`.
- `core_rst`, `core_en` out 1 — drive core `rst`/`en`.
- `core_key` out N*M — latched key.
- `core_plaintext` out 2N — registered `in_data ^ chain`.
- `core_ciphertext`, `core_done` in 2N/1 — core results.

## Operation
- States: IDLE, READY, CRST, CEN, WAIT, OUT.
- IDLE: `in_ready`=0. On `start`: key_r←`key`, chain←`iv`, clear `timeout_err`, go to READY.
- READY: `in_ready`=1. On `in_valid&in_ready`: blk←`in_data^chain`, last_r←`in_last`, go to CRST.
- CRST: `core_rst`=1 for exactly one cycle, then CEN.
- CEN: `core_en`=1 for exactly one cycle; clear watchdog; go to WAIT.
- WAIT: increment watchdog each cycle.
  - `core_done`=1: out_r←`core_ciphertext`, go to OUT.
  - Otherwise, watchdog reaches `TIMEOUT`: set `timeout_err`, drop the message, go to IDLE.
  - `core_done` takes priority if both occur in the same cycle.
- OUT: `out_valid`=1; `out_data`/`out_last` held stable until accepted. On `out_valid&out_ready`: chain←out_r; go to IDLE if last_r, else READY.
- `in_valid` outside READY is ignored. Data is not consumed.
- `start` outside IDLE is ignored. No effect on key, chain or state.
- `core_plaintext`=blk and `core_key`=key_r, registered and stable from CRST through WAIT.
- All XOR is full 2N-bit bitwise. No arithmetic.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`, `out_valid`, `out_last`, `busy`, `core_en`, `timeout_err` = 0.
  - `out_data`, `core_plaintext`, `core_key` = 0.
  - `core_rst` = 1 while `rst`=1 (`core_rst = rst | (state==CRST)`).
- `rst` mid-message aborts immediately. No output is produced for the in-flight block, and chain is discarded.
- Per-block overhead: input accept → CRST (1) → CEN (1) → WAIT (core latency L cycles) → OUT.
  - Earliest `out_valid` = L+3 cycles after the input handshake.
  - Next `in_ready` is 1 cycle after the output handshake.
- Outputs are registered. No combinational path from `in_valid`, `out_ready` or `core_done` to any output.
- Back-pressure: `out_ready`=0 holds OUT indefinitely. The watchdog does not run in OUT.

## Structure
- Shared package `simon_pkg`:
  - `N`/`M` defaults.
  - `block_t` (2N bits) and `key_t` (N*M bits).
  - State enum `cbc_state_t`.
- One sub-module: `simon_cbc_watchdog`, a loadable down-counter with a `TIMEOUT` width derived via `$clog2`.
- The core itself is instantiated alongside this block at the next level up, not inside it.

## Test plan
1. **Single block, IV=0.** key=1b1a1918131211100b0a090803020100, pt=656b696c20646e75, `in_last`=1 → `out_data`=44c8fc20b9dfa07a, `out_last`=1, then IDLE.
2. **Two-block chain, IV=0, same key.**
   - Blocks: 656b696c20646e75, then 21a3954c99bbce0f.
   - Expected: both outputs = 44c8fc20b9dfa07a, because the second core input equals the first.
   - The bench checks that `core_plaintext` for block 2 equals 656b696c20646e75.
3. **Back-pressure.** Hold `out_ready`=0 for 20 cycles in OUT → `out_valid` stays 1, `out_data` stable, `in_ready`=0. Release → exactly one transfer.
4. **Timeout.** Core model never asserts `core_done` → after 255 WAIT cycles, `timeout_err`=1 and state IDLE. A following `start` clears `timeout_err`.
5. **Reset mid-WAIT.** Pulse `rst` → next cycle all outputs are at reset values and `core_rst`=1 during `rst`. Then a fresh test-1 message yields 44c8fc20b9dfa07a.
6. **Ignored inputs.** `start` pulsed during WAIT, and `in_valid` held during CRST/CEN/WAIT → key, chain and results unchanged versus scenario 2.
